segment: RTL and testbench

SEGMENT -- requirements
Module: segment

---
 rtl/segment.sv | 70 +++++++
 tb/tb_segment.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/segment.sv
// Two-operand N7-bit ALU whose low nibble drives a registered, active-high
// seven-segment display (bit6=a .. bit0=g), blanked when EN is low.
module segment #(
  parameter int N7 = 4
) (
  input  logic [N7-1:0] A,
  input  logic [N7-1:0] B,
  input  logic [1:0]    OP2,
  input  logic          EN,
  output logic [6:0]    out,
  input  logic          clk,
  input  logic          rst_n
);

  logic [N7-1:0] w_result;
  logic [6:0]    w_seg;
  logic [6:0]    r_out;
  logic          w_unused_result;

  // Add and subtract wrap naturally at N7 bits; carry/borrow are dropped.
  always_comb begin
    w_result = '0;
    case (OP2)
      2'b00:   w_result = A + B;
      2'b01:   w_result = A | B;
      2'b10:   w_result = A - B;
      2'b11:   w_result = A ^ B;
      default: w_result = '0;
    endcase
  end

  // Bits above the displayed nibble are computed but never shown.
  assign w_unused_result = ^w_result;

  always_comb begin
    w_seg = 7'b0000000;
    if (EN) begin
      case (w_result[3:0])
        4'h0:    w_seg = 7'b1111110;
        4'h1:    w_seg = 7'b0110000;
        4'h2:    w_seg = 7'b1101101;
        4'h3:    w_seg = 7'b1111001;
        4'h4:    w_seg = 7'b0110011;
        4'h5:    w_seg = 7'b1011011;
        4'h6:    w_seg = 7'b1011111;
        4'h7:    w_seg = 7'b1110000;
        4'h8:    w_seg = 7'b1111111;
        4'h9:    w_seg = 7'b1111011;
        4'hA:    w_seg = 7'b1110111;
        4'hB:    w_seg = 7'b0011111;
        4'hC:    w_seg = 7'b1001110;
        4'hD:    w_seg = 7'b0111101;
        4'hE:    w_seg = 7'b1001111;
        4'hF:    w_seg = 7'b1000111;
        default: w_seg = 7'b0000000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= 7'b0000000;
    end else begin
      r_out <= w_seg;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_segment.sv
// Scoreboard bench for segment: expected patterns are queued when inputs are
// driven and popped one edge later; a second instance exercises N7=8.
`timescale 1ns/1ps
module tb_segment;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] OP2;
  logic       EN;
  logic [6:0] out;

  logic [7:0] A8;
  logic [7:0] B8;
  logic [1:0] OP2_8;
  logic       EN8;
  logic [6:0] out8;

  int checks;
  int errors;
  logic [6:0] sb_q[$];
  logic [6:0] sb8_q[$];

  segment #(.N7(4)) dut (
    .A(A), .B(B), .OP2(OP2), .EN(EN), .out(out), .clk(clk), .rst_n(rst_n)
  );

  segment #(.N7(8)) dut8 (
    .A(A8), .B(B8), .OP2(OP2_8), .EN(EN8), .out(out8), .clk(clk), .rst_n(rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return tbl[d];
  endfunction

  // Reference ALU done at 32 bits; only the low nibble is displayed, and that
  // nibble is the same for any operand width >= 4.
  function automatic logic [6:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic [1:0] op, input logic en);
    logic [31:0] r;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a | b;
      2'b10: r = a - b;
      default: r = a ^ b;
    endcase
    return en ? seg_of(r[3:0]) : 7'b0000000;
  endfunction

  // Drive one input set at the falling edge, queue its expectation, then pop
  // and compare just after the rising edge that loads it.
  task automatic step(input string name, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic en);
    logic [6:0] exp;
    @(negedge clk);
    A = a; B = b; OP2 = op; EN = en;
    sb_q.push_back(model({28'd0, a}, {28'd0, b}, op, en));
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: A=%h B=%h OP2=%b EN=%b out=%b expected=%b", name, a, b, op, en, out, exp);
    end else begin
      $display("ok   %s: A=%h B=%h OP2=%b EN=%b out=%b", name, a, b, op, en, out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    A = 4'h8; B = 4'h0; OP2 = 2'b00; EN = 1'b1;
    A8 = 8'h00; B8 = 8'h00; OP2_8 = 2'b00; EN8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out !== 7'b0000000 || out8 !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_hold: out=%b out8=%b expected=0000000", out, out8);
    end else $display("ok   reset_hold: out=%b", out);
    // Release between edges: output must stay clear until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (out !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_release: out=%b expected=0000000", out);
    end else $display("ok   reset_release: out=%b", out);
    step("first_after_reset", 4'h8, 4'h0, 2'b00, 1'b1);
    // Asynchronous assertion mid-cycle clears out without an edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_async: out=%b expected=0000000", out);
    end else $display("ok   reset_async: out=%b", out);
    @(posedge clk);
    #1;
    checks++;
    if (out !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_edge_held: out=%b expected=0000000", out);
    end else $display("ok   reset_edge_held: out=%b", out);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_wrap();
    step("add_wrap_7p9", 4'h7, 4'h9, 2'b00, 1'b1);
    step("add_2p3", 4'h2, 4'h3, 2'b00, 1'b1);
  endtask

  task automatic test_sub_wrap();
    step("sub_wrap_3m5", 4'h3, 4'h5, 2'b10, 1'b1);
    step("sub_9m2", 4'h9, 4'h2, 2'b10, 1'b1);
  endtask

  task automatic test_or_xor();
    step("or_5_A", 4'h5, 4'hA, 2'b01, 1'b1);
    step("xor_C_A", 4'hC, 4'hA, 2'b11, 1'b1);
  endtask

  task automatic test_blank();
    step("blank_en0", 4'h8, 4'h0, 2'b00, 1'b0);
    step("blank_en1", 4'h8, 4'h0, 2'b00, 1'b1);
  endtask

  // Inputs changing between edges must not disturb the registered output.
  task automatic test_hold();
    logic [6:0] held;
    step("hold_setup", 4'h4, 4'h0, 2'b01, 1'b1);
    held = out;
    A = 4'h1; B = 4'h0; OP2 = 2'b00; EN = 1'b1;
    #2;
    checks++;
    if (out !== 7'b0110011 || held !== 7'b0110011) begin
      errors++;
      $display("FAIL hold_between_edges: out=%b expected=0110011", out);
    end else $display("ok   hold_between_edges: out=%b", out);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      step("b2b_digit", i[3:0], 4'h0, 2'b01, 1'b1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 120; i++) begin
      step("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_wide();
    logic [6:0] exp;
    logic [7:0] wa [3];
    logic [7:0] wb [3];
    logic [1:0] wop [3];
    wa  = '{8'h1F, 8'hF3, 8'h10};
    wb  = '{8'h01, 8'h05, 8'h25};
    wop = '{2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A8 = wa[i]; B8 = wb[i]; OP2_8 = wop[i]; EN8 = 1'b1;
      sb8_q.push_back(model({24'd0, wa[i]}, {24'd0, wb[i]}, wop[i], 1'b1));
      @(posedge clk);
      #1;
      exp = sb8_q.pop_front();
      checks++;
      if (out8 !== exp) begin
        errors++;
        $display("FAIL wide_n8: A=%h B=%h OP2=%b out=%b expected=%b", wa[i], wb[i], wop[i], out8, exp);
      end else $display("ok   wide_n8: A=%h B=%h OP2=%b out=%b", wa[i], wb[i], wop[i], out8);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add_wrap();
    test_sub_wrap();
    test_or_xor();
    test_blank();
    test_hold();
    test_back_to_back();
    test_random();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
